// File: rtl/sha3_host_feeder_pkg.sv
// sha3_host_feeder_pkg: mode/state enums, default sizes and rate lookup shared by the SHA3 host feeder.
package sha3_host_feeder_pkg;
  localparam int MAX_LANES_DEF = 21;
  localparam int OUT_DEPTH_DEF = 16;
  localparam int LANE_W = 5;
  typedef enum logic [2:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512, SHAKE128, SHAKE256} mode_e;
  typedef enum logic [2:0] {IDLE, START, FILL, SEND, COLLECT} state_e;
  // Unsupported encodings 6-7 fold onto SHA3-256.
  function automatic logic [2:0] fold_mode(input logic [2:0] mode);
    return mode > 3'd5 ? 3'd1 : mode;
  endfunction
  function automatic logic [LANE_W-1:0] rate_lanes(input logic [2:0] mode);
    mode_e m;
    m = mode_e'(fold_mode(mode));
    return m == SHA3_224 ? 5'd18 :
           m == SHA3_384 ? 5'd13 :
           m == SHA3_512 ? 5'd9  :
           m == SHAKE128 ? 5'd21 : 5'd17;
  endfunction
endpackage

// File: rtl/sha3_host_feeder_if.sv
// sha3_host_feeder_if: command, lane stream, core and digest-consumer signals of the feeder.
interface sha3_host_feeder_if;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_mode;
  logic [10:0] cmd_d;
  logic        s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic        start, last_block, ready, valid, finish_hash;
  logic [2:0]  cmode;
  logic [10:0] d;
  logic [63:0] dt_i;
  logic [31:0] dt_o_hash;
  logic        m_valid, m_ready, m_last, busy, ovf_err;
  logic [31:0] m_data;
  modport master (
    input  cmd_valid, cmd_mode, cmd_d, s_valid, s_data, s_last, ready, valid, finish_hash, dt_o_hash, m_ready,
    output cmd_ready, s_ready, start, cmode, d, dt_i, last_block, m_valid, m_data, m_last, busy, ovf_err
  );
  modport slave (
    output cmd_valid, cmd_mode, cmd_d, s_valid, s_data, s_last, ready, valid, finish_hash, dt_o_hash, m_ready,
    input  cmd_ready, s_ready, start, cmode, d, dt_i, last_block, m_valid, m_data, m_last, busy, ovf_err
  );
endinterface

// File: rtl/sha3_digest_fifo.sv
// sha3_digest_fifo: synchronous FIFO for {finish, word} digest entries; a push into a full FIFO is only taken alongside a pop.
module sha3_digest_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sha3_host_feeder.sv
// sha3_host_feeder: buffers one rate block of host lanes, streams it to the SHA3 core,
// and queues the returned digest words for a backpressured consumer.
module sha3_host_feeder
  import sha3_host_feeder_pkg::*;
#(
  parameter int MAX_LANES = MAX_LANES_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input logic clk,
  input logic rst_n,
  sha3_host_feeder_if.master host_if
);
  state_e state_q, state_d;
  logic [LANE_W-1:0] cnt_q, cnt_d, idx_q, idx_d, rate;
  logic [2:0] mode_q, mode_d;
  logic [10:0] len_q, len_d;
  logic msg_end_q, msg_end_d, ovf_q, ovf_d, alive_q, last_idx;
  logic [63:0] lane_q [MAX_LANES];
  logic push, pop, full, empty, drop;
  logic [32:0] head;
  assign rate = rate_lanes(mode_q);
  assign last_idx = idx_q == cnt_q - 1'b1;
  assign push = state_q == COLLECT && host_if.valid;
  assign pop = !empty && host_if.m_ready;
  assign drop = push && full && !pop;
  // alive_q keeps cmd_ready low while reset is held
  assign host_if.cmd_ready = alive_q && state_q == IDLE;
  assign host_if.s_ready = state_q == FILL;
  assign host_if.start = state_q == START;
  assign host_if.cmode = mode_q;
  assign host_if.d = len_q;
  assign host_if.dt_i = state_q == SEND ? lane_q[idx_q] : '0;
  assign host_if.last_block = state_q == SEND && msg_end_q && last_idx;
  assign host_if.busy = state_q != IDLE;
  assign host_if.ovf_err = ovf_q;
  assign host_if.m_valid = !empty;
  assign host_if.m_data = empty ? '0 : head[31:0];
  assign host_if.m_last = !empty && head[32];
  sha3_digest_fifo #(.DEPTH(OUT_DEPTH), .W(33)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
    .wdata_i({host_if.finish_hash, host_if.dt_o_hash}), .rdata_o(head),
    .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    mode_d = mode_q;
    len_d = len_q;
    msg_end_d = msg_end_q;
    ovf_d = ovf_q || drop;
    case (state_q)
      IDLE: if (host_if.cmd_valid && host_if.cmd_ready) begin
        mode_d = fold_mode(host_if.cmd_mode);
        len_d = host_if.cmd_d;
        ovf_d = 1'b0;
        state_d = START;
      end
      START: begin
        cnt_d = '0;
        idx_d = '0;
        msg_end_d = 1'b0;
        state_d = FILL;
      end
      FILL: if (host_if.s_valid) begin
        cnt_d = cnt_q + 1'b1;
        msg_end_d = host_if.s_last;
        state_d = (host_if.s_last || cnt_d == rate) ? SEND : FILL;
      end
      SEND: if (host_if.ready) begin
        idx_d = last_idx ? '0 : idx_q + 1'b1;
        cnt_d = last_idx ? '0 : cnt_q;
        state_d = !last_idx ? SEND : msg_end_q ? COLLECT : FILL;
      end
      COLLECT: if (host_if.valid && host_if.finish_hash) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (state_q == FILL && host_if.s_valid) lane_q[cnt_q] <= host_if.s_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      mode_q <= '0;
      len_q <= '0;
      msg_end_q <= 1'b0;
      ovf_q <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      len_q <= len_d;
      msg_end_q <= msg_end_d;
      ovf_q <= ovf_d;
      alive_q <= 1'b1;
    end
endmodule

// File: tb/tb_sha3_host_feeder.sv
// tb_sha3_host_feeder: drives hash commands and lane streams, plays the SHA3 core,
// and checks lanes, last_block and the digest stream against a queue-based model.
module tb_sha3_host_feeder;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  sha3_host_feeder_if hif();
  sha3_host_feeder dut (.clk(clk), .rst_n(rst_n), .host_if(hif));
  int total = 0, bad = 0;
  logic [63:0] lanes[$];
  logic [32:0] exp_q[$], got_q[$];
  bit hold_m = 1'b1;
  int rates[8] = '{18, 17, 13, 9, 21, 17, 17, 17};
  int words[4] = '{7, 8, 12, 16};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    hif.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      hif.m_ready = !hold_m && ($urandom_range(3) != 0);
    end
  end
  always @(negedge clk)
    if (rst_n && hif.m_valid && hif.m_ready) got_q.push_back({hif.m_last, hif.m_data});
  task automatic chk_reset();
    chk("rst_cmd_ready", hif.cmd_ready, 0);
    chk("rst_s_ready", hif.s_ready, 0);
    chk("rst_start", hif.start, 0);
    chk("rst_last_block", hif.last_block, 0);
    chk("rst_dt_i", hif.dt_i, 0);
    chk("rst_cmode_d", {hif.cmode, hif.d}, 0);
    chk("rst_m_valid", hif.m_valid, 0);
    chk("rst_busy_ovf", {hif.busy, hif.ovf_err}, 0);
  endtask
  task automatic do_cmd(input logic [2:0] mode, input logic [10:0] dl);
    int n = 0;
    hif.cmd_valid = 1'b1;
    hif.cmd_mode = mode;
    hif.cmd_d = dl;
    while (!hif.cmd_ready && n < 50) begin step(); n++; end
    chk("cmd_ready", hif.cmd_ready, 1);
    step();
    hif.cmd_valid = 1'b0;
    chk("start_hi", hif.start, 1);
    chk("cmode", hif.cmode, mode > 5 ? 1 : mode);
    chk("d", hif.d, dl);
    chk("ovf_clr", hif.ovf_err, 0);
    step();
    chk("start_lo", hif.start, 0);
    chk("fill_ready", hif.s_ready, 1);
  endtask
  // rmode: 0 ready tied high, 1 random ready, 2 ready pattern 1,0,0,1
  task automatic run_hash(input logic [2:0] mode, input logic [10:0] dl, input int rmode, input int nw);
    int r = rates[mode];
    int nl = lanes.size();
    int base = 0, pat = 0, nwv, stored = 0;
    hif.ready = rmode == 0;
    do_cmd(mode, dl);
    while (base < nl) begin
      int nb = (nl - base < r) ? nl - base : r;
      bit fin = (base + nb == nl);
      int i = 0, g = 0;
      for (int k = 0; k < nb; k++) begin
        int n = 0;
        if (rmode != 0 && $urandom_range(3) == 0) begin hif.s_valid = 1'b0; step(); end
        hif.s_valid = 1'b1;
        hif.s_data = lanes[base + k];
        hif.s_last = (base + k == nl - 1);
        while (!hif.s_ready && n < 50) begin step(); n++; end
        if (!hif.s_ready) chk("s_ready", hif.s_ready, 1);
        step();
      end
      hif.s_valid = 1'b0;
      hif.s_last = 1'b0;
      while (i < nb && g < 400) begin
        hif.ready = rmode == 0 ? 1'b1 : rmode == 2 ? (pat % 4 == 0 || pat % 4 == 3) : 1'($urandom_range(1));
        pat++;
        chk("dt_i", hif.dt_i, lanes[base + i]);
        chk("last_block", hif.last_block, fin && i == nb - 1);
        chk("d_hold", hif.d, dl);
        if (hif.ready) i++;
        step();
        g++;
      end
      if (i < nb) chk("send_timeout", i, nb);
      if (rmode != 0) hif.ready = 1'b0;
      base += nb;
    end
    chk("no_extra_block", hif.s_ready, 0);
    chk("collect_busy", hif.busy, 1);
    nwv = nw >= 0 ? nw : mode < 4 ? words[mode] : (dl / 32 < 1 ? 1 : dl / 32 > 16 ? 16 : dl / 32);
    for (int w = 0; w < nwv; w++) begin
      if (rmode != 0 && $urandom_range(2) == 0) begin hif.valid = 1'b0; step(); end
      hif.valid = 1'b1;
      hif.dt_o_hash = $urandom;
      hif.finish_hash = (w == nwv - 1);
      if (!hold_m || stored < 16) begin
        exp_q.push_back({hif.finish_hash, hif.dt_o_hash});
        stored++;
      end
      step();
    end
    hif.valid = 1'b0;
    hif.finish_hash = 1'b0;
    chk("back_idle", hif.busy, 0);
  endtask
  task automatic drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 1000) begin step(); n++; end
    repeat (4) step();
    chk("digest_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("digest", got_q[i], exp_q[i]);
    chk("fifo_empty", hif.m_valid, 0);
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic rand_lanes(input int n);
    lanes.delete();
    for (int i = 0; i < n; i++) lanes.push_back({$urandom, $urandom});
  endtask
  initial begin
    {hif.cmd_valid, hif.cmd_mode, hif.cmd_d, hif.s_valid, hif.s_data, hif.s_last} = '0;
    {hif.ready, hif.valid, hif.finish_hash, hif.dt_o_hash} = '0;
    #1 rst_n = 1'b0;
    repeat (2) step();
    chk_reset();
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", hif.cmd_ready, 1);
    hold_m = 1'b0;
    lanes.delete();
    repeat (16) lanes.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_hash(3'd3, 11'd0, 0, -1);
    drain();
    lanes.delete();
    lanes.push_back(64'h8899AABBCCDDEEFF);
    lanes.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_hash(3'd1, 11'd0, 1, -1);
    drain();
    rand_lanes(17);
    run_hash(3'd5, 11'd128, 1, -1);
    drain();
    rand_lanes(20);
    run_hash(3'd0, 11'd0, 2, -1);
    drain();
    hold_m = 1'b1;
    rand_lanes(3);
    run_hash(3'd3, 11'd0, 0, 17);
    chk("ovf_set", hif.ovf_err, 1);
    chk("fifo_full_valid", hif.m_valid, 1);
    hold_m = 1'b0;
    drain();
    chk("ovf_sticky", hif.ovf_err, 1);
    rand_lanes(9);
    hif.ready = 1'b0;
    do_cmd(3'd3, 11'd0);
    for (int i = 0; i < 9; i++) begin
      hif.s_valid = 1'b1;
      hif.s_data = lanes[i];
      hif.s_last = (i == 8);
      step();
    end
    hif.s_valid = 1'b0;
    hif.s_last = 1'b0;
    hif.ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk_reset();
    step();
    chk_reset();
    rst_n = 1'b1;
    hif.ready = 1'b0;
    step();
    got_q.delete();
    exp_q.delete();
    rand_lanes(5);
    run_hash(3'd0, 11'd0, 1, -1);
    drain();
    for (int k = 0; k < 6; k++) begin
      logic [2:0] m;
      m = 3'($urandom_range(5));
      rand_lanes($urandom_range(1, 45));
      run_hash(m, m > 3 ? 11'(32 * $urandom_range(1, 16)) : 11'd0, 1, -1);
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
